enable_scheduler: RTL and testbench

ENABLE_SCHEDULER -- requirements
Module: enable_scheduler

---
 rtl/enable_sched_pkg.sv | 24 ++
 rtl/enable_scheduler_rr_arbiter.sv | 35 +++
 rtl/enable_scheduler.sv | 125 ++++++++++++
 tb/tb_enable_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enable_sched_pkg.sv
// Shared definitions for the enable scheduler slice.
//   stateT       - scheduler FSM state encoding (IDLE, RUN, DONE)
//   DEF_NUM_REQ  - default number of requesters
//   DEF_PER_W    - default divider period width
//   DEF_LEN_W    - default burst-length width
//   ptrWidth()   - width of a round-robin pointer for n requesters
package enable_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_PER_W   = 4;
    localparam int DEF_LEN_W   = 8;

    // A single requester still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enable_scheduler_rr_arbiter.sv
// Combinational round-robin selector.
//   iReq   - request vector, one bit per requester
//   iPtr   - index of the highest-priority requester for this decision
//   oGrant - one-hot selected requester (zero when nothing is requested)
//   oValid - high when some requester was selected
module rr_arbiter
    import enable_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptrWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [PTR_W-1:0]   iPtr,
    output logic [NUM_REQ-1:0] oGrant,
    output logic               oValid
);

    logic [PTR_W-1:0] idx;

    // Walk upward from the pointer with wrap-around; the first request hit wins.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        oGrant = '0;
        oValid = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(iPtr) + i) % NUM_REQ);
            if (!oValid && iReq[idx]) begin
                oGrant[idx] = 1'b1;
                oValid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enable_scheduler.sv
// Shared enable-tick generator time-multiplexed between NUM_REQ requesters.
// A requester is picked round-robin, receives iBurstLen enable ticks spaced
// iPeriod+1 cycles apart, then a one-cycle done pulse.
//   iClk      - clock, all state on rising edge
//   iRst      - synchronous active-high reset
//   iReq      - per-requester level request, held until its oDone
//   iPeriod   - tick interval minus one, captured at grant
//   iBurstLen - number of ticks to issue, captured at grant
//   oGrant    - one-hot current owner (registered), zero when idle
//   oEnable   - one-cycle tick to the owner only
//   oDone     - one-cycle completion pulse to the owner (registered)
//   oBusy     - high whenever the FSM is not IDLE
module enable_scheduler
    import enable_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PER_W   = DEF_PER_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [PER_W-1:0]   iPeriod,
    input  logic [LEN_W-1:0]   iBurstLen,
    output logic [NUM_REQ-1:0] oGrant,
    output logic [NUM_REQ-1:0] oEnable,
    output logic [NUM_REQ-1:0] oDone,
    output logic               oBusy
);

    localparam int PTR_W = ptrWidth(NUM_REQ);

    stateT              state;
    stateT              nextState;
    logic [PTR_W-1:0]   rPtr;
    logic [PTR_W-1:0]   ptrAfter;
    logic [PER_W-1:0]   rCnt;
    logic [PER_W-1:0]   rPeriod;
    logic [LEN_W-1:0]   rRemain;
    logic [NUM_REQ-1:0] arbGrant;
    logic               arbValid;
    logic               tick;
    logic               reqHeld;
    logic               lastTick;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uArb (
        .iReq   (iReq),
        .iPtr   (rPtr),
        .oGrant (arbGrant),
        .oValid (arbValid)
    );

    // Next-state and decoded outputs. Only the owner's request bit matters
    // while busy; other requesters wait for IDLE.
    always_comb begin
        nextState = state;
        tick      = (state == RUN) && (rCnt == rPeriod);
        reqHeld   = |(iReq & oGrant);
        lastTick  = tick && (rRemain == LEN_W'(1));
        oEnable   = tick ? oGrant : '0;
        oBusy     = (state != IDLE);
        case (state)
            IDLE: if (arbValid) nextState = (iBurstLen == '0) ? DONE : RUN;
            // A dropped request ends the burst, but a tick due this cycle still goes out.
            RUN:  if (lastTick || !reqHeld) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Pointer moves to the requester just after the one being released.
    always_comb begin
        ptrAfter = rPtr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oGrant[i]) ptrAfter = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            rPtr    <= '0;
            rCnt    <= '0;
            rRemain <= '0;
            rPeriod <= '0;
            oGrant  <= '0;
            oDone   <= '0;
        end else begin
            state <= nextState;
            oDone <= '0;
            case (state)
                IDLE: begin
                    if (arbValid) begin
                        oGrant  <= arbGrant;
                        rPeriod <= iPeriod;
                        rRemain <= iBurstLen;
                        rCnt    <= '0;
                        // Zero-length burst goes straight to DONE, so the pulse starts now.
                        if (iBurstLen == '0) oDone <= arbGrant;
                    end
                end
                RUN: begin
                    if (tick) begin
                        rCnt    <= '0;
                        rRemain <= rRemain - LEN_W'(1);
                    end else begin
                        rCnt <= rCnt + PER_W'(1);
                    end
                    if (nextState == DONE) oDone <= oGrant;
                end
                DONE: begin
                    oGrant <= '0;
                    rPtr   <= ptrAfter;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enable_scheduler.sv
// Self-checking bench for enable_scheduler: a cycle-level behavioural model
// derived from burst arithmetic, a per-cycle comparator, an event log and
// directed scenarios with literal expectations.
module tb_enable_scheduler;
    import enable_sched_pkg::*;

    localparam int N  = DEF_NUM_REQ;
    localparam int PW = DEF_PER_W;
    localparam int LW = DEF_LEN_W;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic [N-1:0]  iReq = '0;
    logic [PW-1:0] iPeriod = '0;
    logic [LW-1:0] iBurstLen = '0;
    logic [N-1:0]  oGrant, oEnable, oDone;
    logic          oBusy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 iClk = ~iClk;

    enable_scheduler #(.NUM_REQ(N), .PER_W(PW), .LEN_W(LW)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (iReq),
        .iPeriod   (iPeriod),
        .iBurstLen (iBurstLen),
        .oGrant    (oGrant),
        .oEnable   (oEnable),
        .oDone     (oDone),
        .oBusy     (oBusy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(posedge iClk) cyc++;

    // Behavioural model: a burst is described by its owner, interval and
    // length; tick k of a burst falls on RUN cycle k*interval.
    int mPhase = M_IDLE;
    int mOwner = -1;
    int mPtr = 0, mInt = 1, mLen = 0, mRunCyc = 0, mTicks = 0;
    logic [N-1:0] eGrant = '0, eEnable = '0, eDone = '0;
    logic         eBusy = 1'b0;

    always @(posedge iClk) begin
        if (iRst) begin
            mPhase = M_IDLE;
            mOwner = -1;
            mPtr   = 0;
        end else begin
            case (mPhase)
                M_IDLE: if (iReq != '0) begin
                    for (int k = 0; k < N; k++)
                        if (mOwner < 0 && iReq[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
                    mInt    = int'(iPeriod) + 1;
                    mLen    = int'(iBurstLen);
                    mRunCyc = 1;
                    mTicks  = 0;
                    mPhase  = (mLen == 0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (mRunCyc % mInt == 0) mTicks++;
                    if (mTicks == mLen || !iReq[mOwner]) mPhase = M_DONE;
                    else mRunCyc++;
                end
                default: begin
                    mPtr   = (mOwner + 1) % N;
                    mOwner = -1;
                    mPhase = M_IDLE;
                end
            endcase
        end
        eGrant  = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
        eEnable = (mPhase == M_RUN && mRunCyc % mInt == 0) ? eGrant : '0;
        eDone   = (mPhase == M_DONE) ? eGrant : '0;
        eBusy   = (mPhase != M_IDLE);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge iClk) begin
        check("model grant",  32'(oGrant),  32'(eGrant));
        check("model enable", 32'(oEnable), 32'(eEnable));
        check("model done",   32'(oDone),   32'(eDone));
        check("model busy",   32'(oBusy),   32'(eBusy));
    end

    // Event log for the literal per-scenario expectations.
    int grantQ[$], grantCycQ[$], tickCycQ[$], doneQ[$], doneCycQ[$];
    logic [N-1:0] prevGrant = '0;

    always @(negedge iClk) begin
        if (oGrant != '0 && prevGrant == '0) begin
            grantQ.push_back(int'(oGrant));
            grantCycQ.push_back(cyc);
        end
        if (oEnable != '0) tickCycQ.push_back(cyc);
        if (oDone != '0) begin
            doneQ.push_back(int'(oDone));
            doneCycQ.push_back(cyc);
        end
        prevGrant = oGrant;
    end

    task automatic clear_log();
        grantQ.delete();
        grantCycQ.delete();
        tickCycQ.delete();
        doneQ.delete();
        doneCycQ.delete();
    endtask

    task automatic start(input logic [N-1:0] r, input logic [PW-1:0] p, input logic [LW-1:0] l);
        @(posedge iClk);
        #1;
        clear_log();
        iPeriod   = p;
        iBurstLen = l;
        iReq      = r;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge iClk);
            seen = (oDone != '0);
        end
        check({name, " done within budget"}, 32'(seen), 32'd1);
    endtask

    task automatic settle();
        repeat (2) @(negedge iClk);
        #1;
    endtask

    // RUN-cycle index (1-based) of a logged cycle relative to the first grant.
    function automatic int runIdx(input int c);
        return c - qat(grantCycQ, 0) + 1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;

        // Reset state.
        repeat (2) @(posedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk);
        check("reset grant",  32'(oGrant),  0);
        check("reset enable", 32'(oEnable), 0);
        check("reset done",   32'(oDone),   0);
        check("reset busy",   32'(oBusy),   0);

        // Single burst: ticks on RUN cycles 16, 32, 48; done on 49.
        start(4'b0001, 4'd15, 8'd3);
        wait_done(80, "s1");
        iReq = '0;
        settle();
        check("s1 grant value", qat(grantQ, 0), 1);
        check("s1 tick count",  tickCycQ.size(), 3);
        check("s1 tick1 idx",   runIdx(qat(tickCycQ, 0)), 16);
        check("s1 tick2 idx",   runIdx(qat(tickCycQ, 1)), 32);
        check("s1 tick3 idx",   runIdx(qat(tickCycQ, 2)), 48);
        check("s1 done value",  qat(doneQ, 0), 1);
        check("s1 done idx",    runIdx(qat(doneCycQ, 0)), 49);
        check("s1 busy after",  32'(oBusy), 0);

        // Fairness: all four requesting, period 0, length 2.
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1 iRst = 1'b0;
        start(4'b1111, 4'd0, 8'd2);
        for (int k = 0; k < 5; k++) wait_done(20, "s2");
        iReq = '0;
        settle();
        check("s2 grant0", qat(grantQ, 0), 1);
        check("s2 grant1", qat(grantQ, 1), 2);
        check("s2 grant2", qat(grantQ, 2), 4);
        check("s2 grant3", qat(grantQ, 3), 8);
        check("s2 grant4", qat(grantQ, 4), 1);
        check("s2 tick count", tickCycQ.size(), 10);
        check("s2 first tick idx", runIdx(qat(tickCycQ, 0)), 1);
        check("s2 ticks consecutive", qat(tickCycQ, 1) - qat(tickCycQ, 0), 1);
        check("s2 grant spacing", qat(grantCycQ, 1) - qat(grantCycQ, 0), 4);
        check("s2 five grants span", qat(grantCycQ, 4) - qat(grantCycQ, 0), 16);

        // Zero length: grant and done in the same single cycle, no ticks.
        start(4'b0100, 4'd0, 8'd0);
        wait_done(10, "s3");
        iReq = '0;
        settle();
        check("s3 grant value", qat(grantQ, 0), 4);
        check("s3 tick count",  tickCycQ.size(), 0);
        check("s3 done value",  qat(doneQ, 0), 4);
        check("s3 done same cycle", qat(doneCycQ, 0) - qat(grantCycQ, 0), 0);
        // Pointer is now 3, so requester 3 beats requester 0.
        start(4'b1001, 4'd0, 8'd1);
        wait_done(10, "s3b");
        iReq = '0;
        settle();
        check("s3 pointer after zero-length", qat(grantQ, 0), 8);

        // Abort after the second tick.
        start(4'b0010, 4'd3, 8'd10);
        nt = 0;
        for (int k = 0; k < 40 && nt < 2; k++) begin
            @(negedge iClk);
            if (oEnable != '0) nt++;
        end
        check("s4 reached two ticks", nt, 2);
        iReq = '0;
        wait_done(5, "s4");
        settle();
        check("s4 grant value", qat(grantQ, 0), 2);
        check("s4 tick count",  tickCycQ.size(), 2);
        check("s4 tick2 idx",   runIdx(qat(tickCycQ, 1)), 8);
        check("s4 done value",  qat(doneQ, 0), 2);
        check("s4 done idx",    runIdx(qat(doneCycQ, 0)), 9);

        // Reset mid-burst: everything clears, no done pulse, pointer back to 0.
        start(4'b0100, 4'd1, 8'd10);
        repeat (6) @(negedge iClk);
        iRst = 1'b1;
        iReq = '0;
        @(negedge iClk);
        check("s5 grant after reset",  32'(oGrant),  0);
        check("s5 enable after reset", 32'(oEnable), 0);
        check("s5 done after reset",   32'(oDone),   0);
        check("s5 busy after reset",   32'(oBusy),   0);
        iRst = 1'b0;
        settle();
        check("s5 no done pulse", doneQ.size(), 0);
        start(4'b0101, 4'd0, 8'd0);
        wait_done(10, "s5b");
        iReq = '0;
        settle();
        check("s5 pointer reset", qat(grantQ, 0), 1);
        start(4'b1000, 4'd0, 8'd1);
        wait_done(10, "s5c");
        iReq = '0;
        settle();
        check("s5 requester3 granted", qat(grantQ, 0), 8);

        // Configuration changes mid-burst are ignored.
        start(4'b0001, 4'd15, 8'd3);
        nt = 0;
        for (int k = 0; k < 40 && nt < 1; k++) begin
            @(negedge iClk);
            if (oEnable != '0) nt++;
        end
        check("s6 reached first tick", nt, 1);
        iPeriod   = 4'd1;
        iBurstLen = 8'd50;
        wait_done(60, "s6");
        iReq = '0;
        settle();
        check("s6 tick count", tickCycQ.size(), 3);
        check("s6 tick2 idx",  runIdx(qat(tickCycQ, 1)), 32);
        check("s6 tick3 idx",  runIdx(qat(tickCycQ, 2)), 48);
        check("s6 done idx",   runIdx(qat(doneCycQ, 0)), 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
